// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad emulator: FSM states, the
// key-code to column/row map and the bounce LFSR seed.
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BOUNCE_IN,
        ST_HOLD,
        ST_BOUNCE_OUT,
        ST_GAP
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // One-hot column and row, bit 3 = column/row 0.
    typedef struct packed {
        logic [3:0] col;
        logic [3:0] row;
    } key_pos_t;

    function automatic key_pos_t key_map(input logic [3:0] code);
        key_pos_t p;
        p = '0;
        case (code)
            4'h1: p = '{col: 4'b1000, row: 4'b1000};
            4'h2: p = '{col: 4'b0100, row: 4'b1000};
            4'h3: p = '{col: 4'b0010, row: 4'b1000};
            4'hA: p = '{col: 4'b0001, row: 4'b1000};
            4'h4: p = '{col: 4'b1000, row: 4'b0100};
            4'h5: p = '{col: 4'b0100, row: 4'b0100};
            4'h6: p = '{col: 4'b0010, row: 4'b0100};
            4'hB: p = '{col: 4'b0001, row: 4'b0100};
            4'h7: p = '{col: 4'b1000, row: 4'b0010};
            4'h8: p = '{col: 4'b0100, row: 4'b0010};
            4'h9: p = '{col: 4'b0010, row: 4'b0010};
            4'hC: p = '{col: 4'b0001, row: 4'b0010};
            4'hD: p = '{col: 4'b1000, row: 4'b0001};
            4'h0: p = '{col: 4'b0100, row: 4'b0001};
            4'hE: p = '{col: 4'b0010, row: 4'b0001};
            4'hF: p = '{col: 4'b0001, row: 4'b0001};
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Press-request handshake between a test controller and the keypad emulator.
interface keypad_emulator_if;

    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_key;
    logic [15:0] req_hold;
    logic        busy;
    logic        done;

    modport master (
        output req_valid, req_key, req_hold,
        input  req_ready, busy, done
    );

    modport slave (
        input  req_valid, req_key, req_hold,
        output req_ready, busy, done
    );

endinterface

// File: rtl/keypad_bounce_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying pseudo-random contact
// bits during bounce phases; advances only when step_en is high.
module keypad_bounce_lfsr
    import keypad_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic step_en,
    output logic bit_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        feedback;

    always_comb begin
        feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d   = lfsr_q;
        if (step_en) begin
            lfsr_d = {lfsr_q[14:0], feedback};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_o = lfsr_q[15];

endmodule

// File: rtl/keypad_emulator.sv
// Emulates one key of a 4x4 matrix keypad: on request it presses a key with
// contact bounce, holds it, releases it with bounce, then enforces a gap.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int unsigned CLK_HZ             = 27_000_000,
    parameter int unsigned TICK_CYCLES        = CLK_HZ / 1000,
    parameter int unsigned BOUNCE_TICKS       = 5,
    parameter int unsigned BOUNCE_STEP_CYCLES = 1350,
    parameter int unsigned GAP_TICKS          = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        columnas,
    output logic [3:0]        filas,
    keypad_emulator_if.slave  req
);

    localparam int unsigned CYC_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned STEP_W = (BOUNCE_STEP_CYCLES > 1) ? $clog2(BOUNCE_STEP_CYCLES) : 1;

    localparam logic [CYC_W-1:0]  CYC_LAST    = CYC_W'((TICK_CYCLES > 0) ? TICK_CYCLES - 1 : 0);
    localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'((BOUNCE_STEP_CYCLES > 0) ? BOUNCE_STEP_CYCLES - 1 : 0);
    localparam logic [15:0]       BOUNCE_LAST = 16'((BOUNCE_TICKS > 0) ? BOUNCE_TICKS - 1 : 0);
    localparam logic [15:0]       GAP_LAST    = 16'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    state_e             state_q, state_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [15:0]        tick_q, tick_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic               contact_q, contact_d;
    key_pos_t           pos_q, pos_d;
    logic [15:0]        hold_last_q, hold_last_d;
    logic [3:0]         filas_q, filas_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;

    logic               tick_end;
    logic               step_end;
    logic               lfsr_step;
    logic               lfsr_bit;

    keypad_bounce_lfsr u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .step_en (lfsr_step),
        .bit_o   (lfsr_bit)
    );

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        tick_d      = tick_q;
        step_d      = step_q;
        contact_d   = contact_q;
        pos_d       = pos_q;
        hold_last_d = hold_last_q;
        done_d      = 1'b0;
        lfsr_step   = 1'b0;
        tick_end    = (cyc_q == CYC_LAST);
        step_end    = (step_q == STEP_LAST);

        if (state_q != ST_IDLE) begin
            cyc_d  = tick_end ? '0 : cyc_q + CYC_W'(1);
            tick_d = tick_end ? tick_q + 16'd1 : tick_q;
            step_d = step_end ? '0 : step_q + STEP_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (req.req_valid && ready_q) begin
                    pos_d       = key_map(req.req_key);
                    hold_last_d = (req.req_hold == '0) ? '0 : req.req_hold - 16'd1;
                    state_d     = (BOUNCE_TICKS == 0) ? ST_HOLD : ST_BOUNCE_IN;
                    contact_d   = 1'b1;
                end
            end
            ST_BOUNCE_IN: begin
                if (step_end) begin
                    contact_d = lfsr_bit;
                    lfsr_step = 1'b1;
                end
                if (tick_end && tick_q == BOUNCE_LAST) begin
                    state_d   = ST_HOLD;
                    contact_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (tick_end && tick_q == hold_last_q) begin
                    state_d   = (BOUNCE_TICKS == 0) ? ST_GAP : ST_BOUNCE_OUT;
                    contact_d = 1'b0;
                end
            end
            ST_BOUNCE_OUT: begin
                if (step_end) begin
                    contact_d = lfsr_bit;
                    lfsr_step = 1'b1;
                end
                if (tick_end && tick_q == BOUNCE_LAST) begin
                    state_d   = ST_GAP;
                    contact_d = 1'b0;
                end
            end
            ST_GAP: begin
                if (GAP_TICKS == 0 || (tick_end && tick_q == GAP_LAST)) begin
                    state_d   = ST_IDLE;
                    contact_d = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                contact_d = 1'b0;
            end
        endcase

        // Every state starts its own timing from zero, including the
        // bounce sample grid, so bounce edges align to state entry.
        if (state_d != state_q) begin
            cyc_d  = '0;
            tick_d = '0;
            step_d = '0;
        end

        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE) && (state_q == ST_IDLE);
        filas_d = (contact_q && columnas == pos_q.col) ? pos_q.row : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cyc_q       <= '0;
            tick_q      <= '0;
            step_q      <= '0;
            contact_q   <= 1'b0;
            pos_q       <= '0;
            hold_last_q <= '0;
            filas_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            tick_q      <= tick_d;
            step_q      <= step_d;
            contact_q   <= contact_d;
            pos_q       <= pos_d;
            hold_last_q <= hold_last_d;
            filas_q     <= filas_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    assign filas         = filas_q;
    assign req.busy      = busy_q;
    assign req.done      = done_q;
    assign req.req_ready = ready_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: two instances (no bounce / 2-tick bounce with
// zero gap) checked every cycle against a timeline model of each press.
module tb_keypad_emulator;

    localparam int T  = 10;
    localparam int S  = 3;
    localparam int B0 = 0;
    localparam int G0 = 1;
    localparam int B1 = 2;
    localparam int G1 = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst;
    logic [1:0]  valid;
    logic [3:0]  col  [2];
    logic [3:0]  key  [2];
    logic [15:0] hold [2];
    logic [3:0]  filas0, filas1;

    keypad_emulator_if if0 ();
    keypad_emulator_if if1 ();

    assign if0.req_valid = valid[0];
    assign if0.req_key   = key[0];
    assign if0.req_hold  = hold[0];
    assign if1.req_valid = valid[1];
    assign if1.req_key   = key[1];
    assign if1.req_hold  = hold[1];

    keypad_emulator #(
        .CLK_HZ(10_000), .TICK_CYCLES(T), .BOUNCE_TICKS(B0),
        .BOUNCE_STEP_CYCLES(S), .GAP_TICKS(G0)
    ) u_dut0 (
        .clk(clk), .reset(rst[0]), .columnas(col[0]), .filas(filas0), .req(if0)
    );

    keypad_emulator #(
        .CLK_HZ(10_000), .TICK_CYCLES(T), .BOUNCE_TICKS(B1),
        .BOUNCE_STEP_CYCLES(S), .GAP_TICKS(G1)
    ) u_dut1 (
        .clk(clk), .reset(rst[1]), .columnas(col[1]), .filas(filas1), .req(if1)
    );

    // Key map written out from the keypad layout: index = key code.
    int kcol [16] = '{1, 0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 3, 3, 0, 2, 3};
    int krow [16] = '{3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 1, 2, 3, 3, 3};

    bit         m_active [2];
    bit         m_done   [2];
    int         m_off    [2];
    int         m_total  [2];
    int         m_holdt  [2];
    int         m_key    [2];
    logic [3:0] e_filas  [2];
    logic [3:0] e_any    [2];
    bit         e_unk    [2];
    bit         e_stable [2];
    bit         e_busy   [2];
    bit         e_done   [2];
    bit         e_ready  [2];
    int         blk_prev [2] = '{-1, -1};
    logic [3:0] col_prev [2];
    logic [3:0] obs_prev [2] = '{4'b0000, 4'b0000};
    bit         rot      [2] = '{1'b0, 1'b0};

    int n_checks = 0;
    int n_fail   = 0;
    int toggles  = 0;

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] v;
        v = 4'b1000;
        return v >> i;
    endfunction

    function automatic int bt(input int d);
        return (d == 0 ? B0 : B1) * T;
    endfunction

    function automatic int gap_cycles(input int d);
        int g;
        g = (d == 0) ? G0 : G1;
        return (g == 0) ? 1 : g * T;
    endfunction

    // Contact during the current cycle: 0, 1, or 2 = bounce-random.
    // blk identifies the bounce sample window (-1 outside bounce).
    function automatic void contact_at(input int d, output int c, output int blk);
        int o, b, h;
        o = m_off[d];
        b = bt(d);
        h = m_holdt[d];
        blk = -1;
        if (!m_active[d])          c = 0;
        else if (o < b)            begin blk = o / S;              c = (blk == 0) ? 1 : 2; end
        else if (o < b + h)        c = 1;
        else if (o < 2 * b + h)    begin blk = 1000 + (o - b - h) / S; c = (blk == 1000) ? 0 : 2; end
        else                       c = 0;
        if (c != 2) blk = -1;
    endfunction

    task automatic chk(input string nm, input int d, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    task automatic model_step(input int d);
        int c, blk, h;
        logic [3:0] kc, kr;
        bit ready_now;
        if (rst[d]) begin
            m_active[d] = 1'b0;
            m_done[d]   = 1'b0;
            e_unk[d]    = 1'b0;
            e_stable[d] = 1'b0;
            e_filas[d]  = 4'b0000;
            blk_prev[d] = -1;
        end else begin
            contact_at(d, c, blk);
            kc = onehot(kcol[m_key[d]]);
            kr = onehot(krow[m_key[d]]);
            e_unk[d]    = (c == 2);
            e_stable[d] = (c == 2) && (blk == blk_prev[d]) && (col[d] == col_prev[d]);
            e_any[d]    = (col[d] == kc) ? kr : 4'b0000;
            e_filas[d]  = (c == 1 && col[d] == kc) ? kr : 4'b0000;
            blk_prev[d] = blk;
            ready_now   = !m_active[d] && !m_done[d];
            m_done[d]   = 1'b0;
            if (m_active[d]) begin
                if (m_off[d] == m_total[d] - 1) begin
                    m_active[d] = 1'b0;
                    m_done[d]   = 1'b1;
                end else begin
                    m_off[d]++;
                end
            end else if (ready_now && valid[d]) begin
                h = (hold[d] == 0) ? 1 : int'(hold[d]);
                m_active[d] = 1'b1;
                m_off[d]    = 0;
                m_key[d]    = int'(key[d]);
                m_holdt[d]  = h * T;
                m_total[d]  = 2 * bt(d) + h * T + gap_cycles(d);
            end
        end
        col_prev[d] = col[d];
        e_busy[d]   = m_active[d];
        e_done[d]   = m_done[d];
        e_ready[d]  = !m_active[d] && !m_done[d];
    endtask

    task automatic compare(input int d);
        logic [3:0] f;
        logic b, dn, r;
        f  = (d == 0) ? filas0 : filas1;
        b  = (d == 0) ? if0.busy : if1.busy;
        dn = (d == 0) ? if0.done : if1.done;
        r  = (d == 0) ? if0.req_ready : if1.req_ready;
        chk("busy", d, b, e_busy[d]);
        chk("done", d, dn, e_done[d]);
        chk("req_ready", d, r, e_ready[d]);
        if (!e_unk[d]) begin
            chk("filas", d, f, e_filas[d]);
        end else begin
            chk("filas_bounce_value", d, (f == 4'b0000 || f == e_any[d]) ? 1 : 0, 1);
            if (e_stable[d]) chk("filas_bounce_grid", d, f, obs_prev[d]);
            else if (f != obs_prev[d]) toggles++;
        end
        obs_prev[d] = f;
    endtask

    task automatic tick();
        for (int d = 0; d < 2; d++) model_step(d);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            compare(d);
            if (rot[d]) col[d] = {col[d][0], col[d][3:1]};
        end
    endtask

    task automatic wait_done(input int d, input int maxc, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(d == 0 ? if0.done : if1.done) && n < maxc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, hits, done_at, dones;
        rst = 2'b11;
        valid = 2'b00;
        for (int d = 0; d < 2; d++) begin
            col[d] = 4'b0000; key[d] = 4'h0; hold[d] = 16'd0; col_prev[d] = 4'b0000;
        end
        repeat (3) tick();
        rst = 2'b00;
        chk("reset_filas", 0, filas0, 4'b0000);
        chk("reset_ready", 0, if0.req_ready, 1);
        chk("reset_busy", 1, if1.busy, 0);

        // Key 5, hold 3, columns scanned in rotation.
        key[0] = 4'h5; hold[0] = 16'd3; col[0] = 4'b1000; valid[0] = 1'b1;
        tick();
        valid[0] = 1'b0; rot[0] = 1'b1;
        hits = 0; done_at = -1;
        for (int i = 1; i <= 45; i++) begin
            tick();
            if (filas0 == 4'b0100) hits++;
            if (if0.done && done_at < 0) done_at = i;
        end
        rot[0] = 1'b0; col[0] = 4'b0000;
        chk("scan_done_latency", 0, done_at, 40);
        chk("scan_row_hits", 0, hits, 8);

        // Every code at its own column, then at other columns.
        for (int code = 0; code < 16; code++) begin
            key[0] = code[3:0]; hold[0] = 16'd1; col[0] = onehot(kcol[code]); valid[0] = 1'b1;
            tick();
            valid[0] = 1'b0;
            repeat (3) tick();
            if (code == 10) chk("keyA_row", 0, filas0, 4'b1000);
            if (code == 0)  chk("key0_row", 0, filas0, 4'b0001);
            if (code == 6)  chk("key6_row", 0, filas0, 4'b0100);
            col[0] = onehot((kcol[code] + 1 + int'($urandom_range(0, 2))) % 4);
            repeat (3) tick();
            col[0] = 4'b1111;
            wait_done(0, 60, n);
            col[0] = 4'b0000;
            repeat (2) tick();
        end

        // Bounced press of key A on the second instance.
        key[1] = 4'hA; hold[1] = 16'd2; col[1] = 4'b0001; valid[1] = 1'b1;
        tick();
        valid[1] = 1'b0;
        wait_done(1, 200, n);
        chk("bounce_done_latency", 1, n, 61);
        chk("bounce_toggles_seen", 1, (toggles > 0) ? 1 : 0, 1);
        col[1] = 4'b0000;
        repeat (3) tick();

        // Back-to-back requests with valid held high.
        key[0] = 4'h1; hold[0] = 16'd1; col[0] = 4'b1000; valid[0] = 1'b1;
        tick();
        key[0] = 4'h2;
        wait_done(0, 60, n);
        chk("b2b_first_done", 0, n, 20);
        n = 0;
        do begin
            tick();
            n++;
        end while (!if0.busy && n < 10);
        chk("b2b_second_accept", 0, n, 2);
        valid[0] = 1'b0; col[0] = 4'b0100;
        wait_done(0, 60, n);
        chk("b2b_second_done", 0, n, 20);
        repeat (3) tick();

        // Reset in the middle of HOLD.
        key[0] = 4'h5; hold[0] = 16'd5; col[0] = 4'b0100; valid[0] = 1'b1;
        tick();
        valid[0] = 1'b0;
        repeat (20) tick();
        chk("midhold_row", 0, filas0, 4'b0100);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        chk("midreset_filas", 0, filas0, 4'b0000);
        chk("midreset_busy", 0, if0.busy, 0);
        chk("midreset_ready", 0, if0.req_ready, 1);
        dones = 0;
        repeat (70) begin
            tick();
            if (if0.done) dones++;
        end
        chk("midreset_no_done", 0, dones, 0);

        // Zero hold with a multi-hot column drive.
        key[0] = 4'h5; hold[0] = 16'd0; col[0] = 4'b1100; valid[0] = 1'b1;
        tick();
        valid[0] = 1'b0;
        wait_done(0, 60, n);
        chk("hold0_done_latency", 0, n, 20);
        repeat (3) tick();

        // Randomised traffic on both instances.
        for (int i = 0; i < 1500; i++) begin
            for (int d = 0; d < 2; d++) begin
                valid[d] = ($urandom_range(0, 9) < 3);
                key[d]   = 4'($urandom_range(0, 15));
                hold[d]  = 16'($urandom_range(0, 2));
                case ($urandom_range(0, 3))
                    0:       col[d] = 4'b0000;
                    1:       col[d] = 4'($urandom_range(0, 15));
                    default: col[d] = onehot(int'($urandom_range(0, 3)));
                endcase
                rst[d] = ($urandom_range(0, 299) == 0);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter CLK_HZ, 27_000_000, input clock frequency in Hz.
REQ-002 Parameter TICK_CYCLES, CLK_HZ/1000, clk cycles per 1 ms tick.
REQ-003 Parameter BOUNCE_TICKS, 5, bounce phase length in ticks, applied at press and at release; 0 disables bounce.
REQ-004 Parameter BOUNCE_STEP_CYCLES, 1350, cycles between bounce contact re-evaluations.
REQ-005 Parameter GAP_TICKS, 2, minimum released time after a press before the next request is accepted.
REQ-006 clk  in  1  single system clock; all logic on posedge clk.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 columnas  in  4  one-hot active-high column drive from the scanner (1000 = column 0 ... 0001 = column 3).
REQ-009 filas  out  4  emulated row lines, active-high (1000 = row 0 ... 0001 = row 3).
REQ-010 req_valid  in  1  press request valid.
REQ-011 req_ready  out  1  high only when a request can be accepted.
REQ-012 req_key  in  4  key code to press.
REQ-013 req_hold  in  16  hold time in ticks once bounce settles; 0 treated as 1.
REQ-014 busy  out  1  high from acceptance until return to IDLE.
REQ-015 done  out  1  one-cycle pulse when a press/release/gap sequence completes.

Function
REQ-016 Key map (code -> column,row): 1->0,0; 2->1,0; 3->2,0; A->3,0; 4->0,1; 5->1,1; 6->2,1; B->3,1; 7->0,2; 8->1,2; 9->2,2; C->3,2; D->0,3; 0->1,3; E->2,3; F->3,3.
REQ-017 Request accepted on the cycle req_valid && req_ready; req_key and req_hold are latched that cycle and ignored afterwards.
REQ-018 States: IDLE -> BOUNCE_IN -> HOLD -> BOUNCE_OUT -> GAP -> IDLE; BOUNCE_IN/BOUNCE_OUT are skipped when BOUNCE_TICKS = 0.
REQ-019 Internal contact flag: 0 in IDLE and GAP, 1 in HOLD, pseudo-random in bounce states (LFSR bit sampled every BOUNCE_STEP_CYCLES, first sample forced 1 on BOUNCE_IN entry, 0 on BOUNCE_OUT entry).
REQ-020 filas registered: next filas = row one-hot of the latched key when contact = 1 and columnas equals its column one-hot exactly; otherwise 0000 (covers columnas 0000 or multi-hot).
REQ-021 Latency: a change of columnas or contact appears on filas exactly 1 cycle later.
REQ-022 Tick counter free-running only while busy, restarts at 0 on every state entry; each state ends after its tick count expires (BOUNCE_TICKS, max(req_hold,1), BOUNCE_TICKS, GAP_TICKS).
REQ-023 done asserts for exactly 1 cycle on the GAP->IDLE transition; req_ready asserts on the following cycle.
REQ-024 req_valid while busy is ignored (no queueing); request accepted only after req_ready rises.
REQ-025 GAP_TICKS = 0 makes GAP last exactly 1 cycle.
REQ-026 Counters width-sized for 16-bit tick counts and TICK_CYCLES-1 without overflow; no wrap inside a state.

Reset
REQ-027 reset high on any cycle returns to IDLE next edge regardless of state: filas 0000, busy 0, done 0, req_ready 1, contact 0, counters 0.
REQ-028 LFSR reloads non-zero seed 16'hACE1 on reset; a reset mid-press produces no done pulse.

Structure
REQ-029 Package keypad_pkg holds the state enum, key map function (code -> column one-hot, row one-hot), and LFSR seed constant; the scanner decoder uses the same map.
REQ-030 One sub-module keypad_bounce_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11), step enable input, 1-bit output.

Verification (TICK_CYCLES=10, BOUNCE_TICKS=0 unless stated, BOUNCE_STEP_CYCLES=3, GAP_TICKS=1)
REQ-031 req_key=5, req_hold=3, columnas cycling 1000/0100/0010/0001 -> filas=0100 exactly 1 cycle after each columnas=0100 during HOLD, 0000 otherwise; done 1 cycle, 40 cycles after acceptance (30 HOLD + 10 GAP).
REQ-032 Each of 16 codes pressed with columnas held at its column -> filas equals the REQ-016 row; with columnas at any other column -> filas 0000.
REQ-033 BOUNCE_TICKS=2, req_key=A, columnas=0001 -> filas toggles between 1000/0000 only on 3-cycle boundaries for 20 cycles, steady 1000 for hold, toggles again 20 cycles, then 0000.
REQ-034 req_valid held high continuously with key 1 then key 2 -> second press accepted only the cycle after done; no overlap of filas activity.
REQ-035 reset asserted mid-HOLD -> next cycle filas=0000, busy=0, req_ready=1, no done pulse.
REQ-036 req_hold=0 -> HOLD lasts exactly 10 cycles; columnas=1100 during HOLD -> filas 0000.
